// File: rtl/sha256_unpad_parse.sv
// Takes one padded 512-bit SHA-256 block as 16 words, checks its padding and length field,
// then replays the original message bytes with first/last strobes.
module sha256_unpad_parse #(
    parameter int MAX_BYTES  = 55,
    parameter bit CHECK_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din32,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [7:0]  dout8,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        byte_start,
    output logic        byte_stop,
    output logic [8:0]  msg_len,
    output logic        done,
    output logic        err_flag
);

    // Handshakes: a word moves when din_valid & din_ready at a rising edge; a byte moves when
    // dout_valid & dout_ready. dout8/strobes stay stable while a byte waits for dout_ready.
    typedef enum logic [2:0] {LOAD, CHECK, EMIT, DONE, ERR} state_t;

    state_t      state, state_nx;
    logic [31:0] words [16];
    logic [7:0]  blk_bytes [64];
    logic [3:0]  wcnt;
    logic [5:0]  bcnt;
    logic        rdy_q;
    logic        hs_in, hs_out;
    logic [63:0] len64;
    logic [5:0]  nb;
    logic [5:0]  nbytes_q;
    logic        last_byte;
    logic        fill_ok;
    logic        blk_valid;

    for (genvar k = 0; k < 64; k++) begin : g_bytes
        assign blk_bytes[k] = words[k / 4][31 - 8 * (k % 4) -: 8];
    end

    assign hs_in     = din_valid && din_ready;
    assign hs_out    = dout_valid && dout_ready;
    assign len64     = {words[14], words[15]};
    assign nb        = len64[8:3];
    assign nbytes_q  = msg_len[8:3];
    assign last_byte = (bcnt == nbytes_q - 6'd1);

    // Bytes after the marker up to the length field must be zero.
    always_comb begin
        fill_ok = 1'b1;
        for (int k = 0; k < 56; k++) begin
            if (CHECK_ZERO && (6'(k) > nb) && (blk_bytes[k] != 8'h00)) fill_ok = 1'b0;
        end
    end

    assign blk_valid = (len64[63:9] == 55'd0) && (len64[2:0] == 3'd0) &&
                       ({26'd0, nb} <= 32'(MAX_BYTES)) && (blk_bytes[nb] == 8'h80) && fill_ok;

    always_comb begin
        state_nx   = state;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout8      = 8'h00;
        byte_start = 1'b0;
        byte_stop  = 1'b0;
        done       = 1'b0;
        case (state)
            LOAD: begin
                din_ready = rdy_q;
                if (hs_in && wcnt == 4'd15) state_nx = CHECK;
            end
            CHECK: begin
                if (!blk_valid)      state_nx = ERR;
                else if (nb == 6'd0) state_nx = DONE;
                else                 state_nx = EMIT;
            end
            EMIT: begin
                dout_valid = 1'b1;
                dout8      = blk_bytes[bcnt];
                byte_start = (bcnt == 6'd0);
                byte_stop  = last_byte;
                if (hs_out && last_byte) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = LOAD;
            end
            ERR:     state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // rdy_q keeps din_ready low for the cycle coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            wcnt     <= 4'd0;
            bcnt     <= 6'd0;
            rdy_q    <= 1'b0;
            msg_len  <= 9'd0;
            err_flag <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            state <= state_nx;
            if (hs_in) begin
                wcnt <= wcnt + 4'd1;
                if (wcnt == 4'd0) err_flag <= 1'b0;
            end
            if (state == CHECK) begin
                msg_len <= len64[8:0];
                bcnt    <= 6'd0;
            end
            if (hs_out) bcnt <= bcnt + 6'd1;
            if (state == ERR) err_flag <= 1'b1;
        end
    end

    // Block storage needs no reset: it is only read after 16 fresh words.
    always_ff @(posedge clk) begin
        if (hs_in) words[wcnt] <= din32;
    end

endmodule

// File: tb/tb_sha256_unpad_parse.sv
// Bench for sha256_unpad_parse: directed table of blocks, backpressure and reset sequences,
// then random blocks checked against a byte-level padding model.
module tb_sha256_unpad_parse;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din32;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  dout8;
    logic        dout_valid;
    logic        dout_ready;
    logic        byte_start;
    logic        byte_stop;
    logic [8:0]  msg_len;
    logic        done;
    logic        err_flag;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [511:0] blk;
        bit           err;
        logic [8:0]   len;
        int           n;
    } vec_t;

    vec_t tbl [9];

    sha256_unpad_parse dut (
        .clk        (clk),
        .rst        (rst),
        .din32      (din32),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout8      (dout8),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .byte_start (byte_start),
        .byte_stop  (byte_stop),
        .msg_len    (msg_len),
        .done       (done),
        .err_flag   (err_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bb(input logic [511:0] blk, input int k);
        return blk[511 - 8 * k -: 8];
    endfunction

    function automatic logic [511:0] setb(input logic [511:0] blk, input int k, input logic [7:0] v);
        logic [511:0] r;
        r = blk;
        r[511 - 8 * k -: 8] = v;
        return r;
    endfunction

    // Reference: decode the padding rules directly on a byte array.
    task automatic model(input logic [511:0] blk, output bit err, output logic [8:0] len);
        logic [7:0] b [64];
        longint unsigned l;
        int n;
        exp_q.delete();
        for (int k = 0; k < 64; k++) b[k] = bb(blk, k);
        l = 0;
        for (int k = 56; k < 64; k++) l = (l << 8) | longint'(b[k]);
        len = l[8:0];
        err = 1'b0;
        if ((l % 8) != 0 || (l / 8) > 55) begin
            err = 1'b1;
        end else begin
            n = int'(l / 8);
            if (b[n] != 8'h80) err = 1'b1;
            for (int k = n + 1; k < 56; k++) if (b[k] != 8'h00) err = 1'b1;
            if (!err) for (int k = 0; k < n; k++) exp_q.push_back(b[k]);
        end
    endtask

    task automatic send_words(input string tag, input logic [511:0] blk, input bit gaps);
        int  i;
        int  guard;
        bit  hs;
        i = 0;
        guard = 0;
        while (i < 16 && guard < 400) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                din_valid = 1'b0;
            end else begin
                din_valid = 1'b1;
                din32     = blk[511 - 32 * i -: 32];
            end
            hs = din_valid && din_ready;
            tick;
            guard++;
            if (hs) begin
                if (i == 0) chk({tag, " err_clear_on_word0"}, err_flag, 0);
                i++;
            end
        end
        din_valid = 1'b0;
        chk({tag, " words_accepted"}, i, 16);
        chk({tag, " ready_drop"}, din_ready, 0);
    endtask

    // Starts in the CHECK cycle; runs until the DUT is back in LOAD.
    task automatic observe(input string tag, input bit exp_err, input logic [8:0] exp_len,
                           input int bp_mode);
        int c, got, n, stall, first_c, last_c, done_c, done_n;
        bit prev_stall;
        logic [7:0] prev_b;
        n = exp_q.size();
        c = 0; got = 0; stall = 0; first_c = -1; last_c = -1; done_c = -1; done_n = 0;
        prev_stall = 1'b0;
        prev_b = 8'h00;
        while (c < 600 && !din_ready) begin
            case (bp_mode)
                0: dout_ready = 1'b1;
                1: begin
                    if (dout_valid && got == 1 && stall < 3) begin
                        dout_ready = 1'b0;
                        stall++;
                    end else begin
                        dout_ready = 1'b1;
                    end
                end
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall) begin
                chk({tag, " held_valid"}, dout_valid, 1);
                chk({tag, " held_byte"}, dout8, prev_b);
            end
            if (dout_valid) begin
                if (first_c < 0) first_c = c;
                if (got < n) chk({tag, " byte"}, dout8, exp_q[got]);
                else chk({tag, " unexpected_byte"}, dout_valid, 0);
                chk({tag, " byte_start"}, byte_start, (got == 0));
                chk({tag, " byte_stop"}, byte_stop, (got == n - 1));
                if (dout_ready) begin
                    last_c = c;
                    got++;
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_b = dout8;
            if (done) begin
                done_n++;
                done_c = c;
            end
            tick;
            c++;
        end
        dout_ready = 1'b1;
        chk({tag, " no_timeout"}, (c < 600), 1);
        chk({tag, " byte_count"}, got, n);
        chk({tag, " done_pulses"}, done_n, exp_err ? 0 : 1);
        chk({tag, " err_flag"}, err_flag, exp_err);
        chk({tag, " msg_len"}, msg_len, exp_len);
        if (n > 0) begin
            chk({tag, " first_valid_latency"}, first_c, 1);
            chk({tag, " done_after_last"}, done_c, last_c + 1);
            if (bp_mode == 0) chk({tag, " throughput"}, last_c - first_c, n - 1);
        end else if (!exp_err) begin
            chk({tag, " empty_done_timing"}, done_c, 1);
        end
        exp_q.delete();
    endtask

    task automatic run_block(input string tag, input logic [511:0] blk, input bit exp_err,
                             input logic [8:0] exp_len, input int bp_mode, input bit gaps);
        send_words(tag, blk, gaps);
        observe(tag, exp_err, exp_len, bp_mode);
    endtask

    task automatic push_bytes(input logic [511:0] blk, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(bb(blk, k));
    endtask

    logic [511:0] abc_blk;

    initial begin
        logic [511:0] blk;
        bit           m_err;
        logic [8:0]   m_len;
        int           n;
        int           kind;
        int           v;

        rst = 1'b1;
        din32 = 32'h0;
        din_valid = 1'b0;
        dout_ready = 1'b1;

        abc_blk = '0;
        abc_blk[511 -: 32] = 32'h61626380;
        abc_blk[31:0] = 32'h00000018;

        // Directed table
        tbl[0] = '{abc_blk, 1'b0, 9'd24, 3};
        blk = '0;
        blk[511 -: 32] = 32'h80000000;
        tbl[1] = '{blk, 1'b0, 9'd0, 0};
        blk = '0;
        for (int k = 0; k < 55; k++) blk = setb(blk, k, 8'(k));
        blk = setb(blk, 55, 8'h80);
        blk[63:0] = 64'd440;
        tbl[2] = '{blk, 1'b0, 9'd440, 55};
        blk = abc_blk;
        blk[511 -: 32] = 32'h61626300;
        tbl[3] = '{blk, 1'b1, 9'd24, 0};
        blk = abc_blk;
        blk[63:0] = 64'd23;
        tbl[4] = '{blk, 1'b1, 9'd23, 0};
        blk = abc_blk;
        blk[63:0] = 64'd448;
        tbl[5] = '{blk, 1'b1, 9'd448 & 9'h1ff, 0};
        blk = setb(abc_blk, 40, 8'h01);
        tbl[6] = '{blk, 1'b1, 9'd24, 0};
        tbl[7] = '{abc_blk, 1'b0, 9'd24, 3};
        blk = '0;
        blk = setb(blk, 0, 8'h5a);
        blk = setb(blk, 1, 8'h80);
        blk[63:0] = 64'd8;
        tbl[8] = '{blk, 1'b0, 9'd8, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset din_ready", din_ready, 0);
        chk("reset dout_valid", dout_valid, 0);
        chk("reset dout8", dout8, 0);
        chk("reset strobes", {byte_start, byte_stop, done}, 0);
        chk("reset msg_len", msg_len, 0);
        chk("reset err_flag", err_flag, 0);
        rst = 1'b0;
        tick;
        chk("post_reset din_ready", din_ready, 1);

        for (int t = 0; t < 9; t++) begin
            push_bytes(tbl[t].blk, tbl[t].n);
            run_block($sformatf("tbl%0d", t), tbl[t].blk, tbl[t].err, tbl[t].len, 0, 1'b0);
        end

        // Backpressure on byte 62 with input gaps
        push_bytes(abc_blk, 3);
        run_block("bp", abc_blk, 1'b0, 9'd24, 1, 1'b1);

        // Reset while the second byte is being presented
        send_words("rst_mid", abc_blk, 1'b0);
        dout_ready = 1'b1;
        tick;
        chk("rst_mid first_byte", dout8, 8'h61);
        tick;
        chk("rst_mid second_byte", dout8, 8'h62);
        rst = 1'b1;
        #1;
        chk("rst_mid dout_valid", dout_valid, 0);
        chk("rst_mid dout8", dout8, 0);
        chk("rst_mid strobes", {byte_start, byte_stop, done}, 0);
        chk("rst_mid msg_len", msg_len, 0);
        chk("rst_mid din_ready", din_ready, 0);
        tick;
        rst = 1'b0;
        tick;
        chk("rst_mid ready_back", din_ready, 1);
        push_bytes(abc_blk, 3);
        run_block("after_rst", abc_blk, 1'b0, 9'd24, 0, 1'b0);

        // Random blocks against the model
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 55);
            blk = '0;
            for (int k = 0; k < n; k++) blk = setb(blk, k, 8'($urandom_range(0, 255)));
            blk = setb(blk, n, 8'h80);
            blk[63:0] = 64'(n * 8);
            kind = $urandom_range(0, 6);
            case (kind)
                0: begin
                    v = $urandom_range(0, 255);
                    if (v == 8'h80) v = 0;
                    blk = setb(blk, n, 8'(v));
                end
                1: if (n < 55) blk = setb(blk, $urandom_range(n + 1, 55), 8'($urandom_range(1, 255)));
                2: blk[63:0] = 64'(n * 8 + $urandom_range(1, 7));
                3: blk[63:0] = 64'((56 + $urandom_range(0, 7)) * 8);
                4: blk[127:96] = 32'($urandom_range(1, 1000));
                default: ;
            endcase
            model(blk, m_err, m_len);
            run_block($sformatf("rnd%0d", r), blk, m_err, m_len, 2, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
